// File: rtl/hwpe_acc_readout_seq.sv
// rtl/hwpe_acc_readout_seq.sv - accumulator read-back command sequencer for the HWPE conv array
module hwpe_acc_readout_seq #(
  parameter logic [6:0] OPCODE = 7'b0001011,
  parameter int         ROWS   = 8,
  parameter int         PES    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode_relu,
  input  logic [9:0]  k_count,
  input  logic [15:0] w_count,
  input  logic [15:0] h_count,
  input  logic [31:0] relu_addr,
  input  logic        tile_rdy,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_instr,
  output logic [31:0] cmd_rs1,
  output logic [31:0] cmd_rs2,
  output logic        busy,
  output logic        done,
  output logic [9:0]  cur_k,
  output logic [15:0] cur_w,
  output logic [15:0] cur_h
);

  localparam logic [2:0] ROW_MAX = 3'(ROWS - 1);
  localparam logic [3:0] PE_MAX  = 4'(PES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_TILE, ISSUE, DONE} state_t;

  state_t      state;
  logic        relu_q;
  logic [9:0]  k_last;
  logic [15:0] w_last;
  logic [15:0] h_last;
  logic [31:0] addr_q;
  logic [2:0]  row;
  logic [3:0]  pe;

  logic        final_tile;
  logic        cmd_last;
  logic        first_last;
  logic [2:0]  next_row;
  logic [3:0]  next_pe;
  logic        next_last;
  logic        any_zero;

  // Build one instruction word; en marks the tile-release command.
  function automatic logic [31:0] build_instr(input logic relu, input logic [2:0] r,
                                              input logic [3:0] p, input logic en);
    logic [4:0] acc;
    acc = {en, 1'b0, r};
    if (relu)
      build_instr = {7'd32, acc, 5'd0, 3'b010, 5'd0, OPCODE};
    else
      build_instr = {7'd16, 1'b0, p, acc, 3'b100, 5'd0, OPCODE};
  endfunction

  assign cmd_rs2 = 32'd0;

  // Position decode: last tile, last command of tile and the following command slot.
  always_comb begin
    final_tile = (cur_k == k_last) && (cur_w == w_last) && (cur_h == h_last);
    any_zero   = (k_count == 10'd0) || (w_count == 16'd0) || (h_count == 16'd0);
    cmd_last   = relu_q ? (row == ROW_MAX) : ((row == ROW_MAX) && (pe == PE_MAX));
    first_last = relu_q ? (ROW_MAX == 3'd0) : ((ROW_MAX == 3'd0) && (PE_MAX == 4'd0));
    next_row   = row;
    next_pe    = pe;
    if (relu_q || (pe == PE_MAX)) begin
      next_row = row + 3'd1;
      next_pe  = 4'd0;
    end else begin
      next_pe = pe + 4'd1;
    end
    next_last = relu_q ? (next_row == ROW_MAX)
                       : ((next_row == ROW_MAX) && (next_pe == PE_MAX));
  end

  // Sequencer FSM with registered command port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_instr <= 32'd0;
      cmd_rs1   <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_k     <= 10'd0;
      cur_w     <= 16'd0;
      cur_h     <= 16'd0;
      relu_q    <= 1'b0;
      k_last    <= 10'd0;
      w_last    <= 16'd0;
      h_last    <= 16'd0;
      addr_q    <= 32'd0;
      row       <= 3'd0;
      pe        <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (any_zero) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              relu_q <= mode_relu;
              k_last <= k_count - 10'd1;
              w_last <= w_count - 16'd1;
              h_last <= h_count - 16'd1;
              addr_q <= relu_addr;
              cur_k  <= 10'd0;
              cur_w  <= 16'd0;
              cur_h  <= 16'd0;
              busy   <= 1'b1;
              state  <= WAIT_TILE;
            end
          end
        end
        WAIT_TILE: begin
          if (tile_rdy) begin
            row       <= 3'd0;
            pe        <= 4'd0;
            cmd_valid <= 1'b1;
            cmd_instr <= build_instr(relu_q, 3'd0, 4'd0, first_last && !final_tile);
            cmd_rs1   <= relu_q ? addr_q : 32'd0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            if (cmd_last) begin
              cmd_valid <= 1'b0;
              if (final_tile) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                // H innermost, then W, then K.
                if (cur_h != h_last) begin
                  cur_h <= cur_h + 16'd1;
                end else begin
                  cur_h <= 16'd0;
                  if (cur_w != w_last) begin
                    cur_w <= cur_w + 16'd1;
                  end else begin
                    cur_w <= 16'd0;
                    cur_k <= cur_k + 10'd1;
                  end
                end
                state <= WAIT_TILE;
              end
            end else begin
              row       <= next_row;
              pe        <= next_pe;
              cmd_instr <= build_instr(relu_q, next_row, next_pe, next_last && !final_tile);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
